// File: rtl/mult_arbiter.sv
// mult_arbiter: round-robin arbiter/sequencer sharing one external 8x8 unsigned
// combinational multiplier between NREQ requesters.
//
// Ports:
//   clk, reset          rising-edge clock, synchronous active-high reset
//   req_valid/req_ready per-requester handshake (req_ready is one-hot)
//   req_a/req_b         packed 8-bit operands, requester i in bits [8i+7:8i]
//   mult_a/mult_b       registered operands driven to the shared multiplier
//   mult_y              product returned by the shared multiplier
//   rsp_valid/rsp_ready result handshake, rsp_id = owning requester, rsp_y = product
//   err                 sticky product-mismatch flag
//
// Optional build macro: MULT_ARB_CHECK_EN
//   defined   -> mult_y is compared against an internal op_a*op_b in MUL;
//                a mismatch sets err until reset
//   undefined -> no compare logic, err tied to 0
//
// state | meaning
// IDLE  | waiting for a request; grant and capture operands in the same cycle
// MUL   | captured operands on mult_a/mult_b; product latched at the edge
// RESP  | result held on rsp_*; leave on rsp_ready

module mult_arbiter #(
  parameter int NREQ = 4,
  parameter int IDW  = $clog2(NREQ)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NREQ-1:0]   req_valid,
  output logic [NREQ-1:0]   req_ready,
  input  logic [8*NREQ-1:0] req_a,
  input  logic [8*NREQ-1:0] req_b,
  output logic [7:0]        mult_a,
  output logic [7:0]        mult_b,
  input  logic [15:0]       mult_y,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [IDW-1:0]    rsp_id,
  output logic [15:0]       rsp_y,
  output logic              err
);

  typedef enum logic [1:0] {IDLE, MUL, RESP} state_t;

  state_t         state_q, state_d;
  logic [IDW-1:0] last_grant_q;
  logic [IDW-1:0] grant_idx;
  logic           grant_found;
  int             scan_idx;
  logic [7:0]     op_a, op_b;
  logic [IDW-1:0] op_id;
  logic [7:0]     sel_a, sel_b;

  // Round-robin pick: first valid requester scanning upward from last_grant+1.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    scan_idx    = 0;
    for (int k = 1; k <= NREQ; k++) begin
      scan_idx = (int'(last_grant_q) + k) % NREQ;
      if (!grant_found && req_valid[IDW'(scan_idx)]) begin
        grant_found = 1'b1;
        grant_idx   = IDW'(scan_idx);
      end
    end
  end

  assign sel_a = req_a[{grant_idx, 3'b000} +: 8];
  assign sel_b = req_b[{grant_idx, 3'b000} +: 8];

  // Gated by reset so no accept strobe is shown while the block is being cleared.
  always_comb begin
    req_ready = '0;
    if (state_q == IDLE && grant_found && !reset)
      req_ready[grant_idx] = 1'b1;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (grant_found) state_d = MUL;
      MUL:     state_d = RESP;
      RESP:    if (rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      last_grant_q <= IDW'(NREQ - 1);
      op_a         <= '0;
      op_b         <= '0;
      op_id        <= '0;
      rsp_valid    <= 1'b0;
      rsp_y        <= '0;
      rsp_id       <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (grant_found) begin
            op_a         <= sel_a;
            op_b         <= sel_b;
            op_id        <= grant_idx;
            last_grant_q <= grant_idx;
          end
        end
        MUL: begin
          rsp_y     <= mult_y;
          rsp_id    <= op_id;
          rsp_valid <= 1'b1;
        end
        RESP: begin
          if (rsp_ready) rsp_valid <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  // Operands only change on an accept in IDLE, so they are stable through MUL.
  assign mult_a = op_a;
  assign mult_b = op_b;

`ifdef MULT_ARB_CHECK_EN
  logic        err_q;
  logic [15:0] ref_y;

  assign ref_y = 16'(op_a) * 16'(op_b);

  always_ff @(posedge clk) begin
    if (reset)                                err_q <= 1'b0;
    else if (state_q == MUL && mult_y != ref_y) err_q <= 1'b1;
  end

  assign err = err_q;
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_mult_arbiter.sv
module tb_mult_arbiter;
  localparam int NREQ = 4;
  localparam int IDW  = 2;

  logic              clk = 1'b0;
  logic              reset;
  logic [NREQ-1:0]   req_valid;
  logic [NREQ-1:0]   req_ready;
  logic [8*NREQ-1:0] req_a, req_b;
  logic [7:0]        mult_a, mult_b;
  logic [15:0]       mult_y;
  logic              rsp_valid, rsp_ready;
  logic [IDW-1:0]    rsp_id;
  logic [15:0]       rsp_y;
  logic              err;
  logic              force_bad = 1'b0;

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;
  int last_acc = -100;
  int model_last = NREQ - 1;

  mult_arbiter #(.NREQ(NREQ), .IDW(IDW)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b),
    .mult_a(mult_a), .mult_b(mult_b), .mult_y(mult_y),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_id(rsp_id), .rsp_y(rsp_y), .err(err)
  );

  // The shared multiplier, with a fault hook for the checker test.
  assign mult_y = force_bad ? 16'h0000 : 16'(mult_a) * 16'(mult_b);

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Reference arbitration: valid requester with smallest rotated distance
  // from the one after the last grant.
  function automatic int ref_grant(input logic [NREQ-1:0] v);
    int best, best_d;
    best = -1;
    best_d = NREQ;
    for (int i = 0; i < NREQ; i++) begin
      if (v[i]) begin
        int d;
        d = (i - model_last - 1 + 2 * NREQ) % NREQ;
        if (d < best_d) begin
          best_d = d;
          best = i;
        end
      end
    end
    return best;
  endfunction

  // Starts and ends just after a falling edge. Holds req_valid high throughout.
  task automatic run_txn(input logic [NREQ-1:0] v, input logic [31:0] a,
                         input logic [31:0] b, input int stall,
                         input int exp_id, input logic [15:0] exp_y);
    int waited;
    logic [7:0] ea, eb;
    req_valid = v;
    req_a     = a;
    req_b     = b;
    rsp_ready = (stall == 0);
    #1;
    waited = 0;
    while (req_ready == '0 && waited < 10) begin
      @(negedge clk); #1;
      waited++;
    end
    chk("accept_grant", 32'(req_ready), 32'(4'b0001 << exp_id));
    if (req_ready == '0) return;
    if (last_acc >= 0) chk("accept_gap_ge3", 32'(cyc - last_acc >= 3), 32'd1);
    last_acc   = cyc;
    model_last = exp_id;
    ea = a[exp_id*8 +: 8];
    eb = b[exp_id*8 +: 8];
    @(negedge clk); #1;
    chk("mul_mult_a", 32'(mult_a), 32'(ea));
    chk("mul_mult_b", 32'(mult_b), 32'(eb));
    chk("mul_req_ready", 32'(req_ready), 32'd0);
    chk("mul_rsp_valid", 32'(rsp_valid), 32'd0);
    @(negedge clk); #1;
    for (int s = 0; s <= stall; s++) begin
      if (s == stall) rsp_ready = 1'b1;
      chk("resp_valid", 32'(rsp_valid), 32'd1);
      chk("resp_y", 32'(rsp_y), 32'(exp_y));
      chk("resp_id", 32'(rsp_id), 32'(exp_id));
      chk("resp_req_ready", 32'(req_ready), 32'd0);
      if (s < stall) begin
        @(negedge clk); #1;
      end
    end
    @(negedge clk); #1;
    chk("idle_rsp_valid", 32'(rsp_valid), 32'd0);
  endtask

  typedef struct {
    logic [NREQ-1:0] valid;
    logic [31:0]     a;
    logic [31:0]     b;
    int              stall;
    int              exp_id;
    logic [15:0]     exp_y;
  } vec_t;

  vec_t tbl[9];

  initial begin
    logic [7:0] blist[8];
    logic [31:0] ra, rb;
    logic [NREQ-1:0] rv;
    int gid, st;
    logic [15:0] ey;

    // Fairness (all valid, a=i+1, b=10), single request, backpressure, rotation.
    tbl[0] = '{4'b1111, 32'h04030201, 32'h0A0A0A0A, 0, 0, 16'd10};
    tbl[1] = '{4'b1111, 32'h04030201, 32'h0A0A0A0A, 0, 1, 16'd20};
    tbl[2] = '{4'b1111, 32'h04030201, 32'h0A0A0A0A, 0, 2, 16'd30};
    tbl[3] = '{4'b1111, 32'h04030201, 32'h0A0A0A0A, 0, 3, 16'd40};
    tbl[4] = '{4'b1111, 32'h04030201, 32'h0A0A0A0A, 0, 0, 16'd10};
    tbl[5] = '{4'b0100, 32'h000C0000, 32'h000D0000, 0, 2, 16'd156};
    tbl[6] = '{4'b0010, 32'h0000FF00, 32'h0000FF00, 5, 1, 16'd65025};
    tbl[7] = '{4'b1010, 32'h07000000, 32'h09000000, 1, 3, 16'd63};
    tbl[8] = '{4'b1010, 32'h0000C800, 32'h00000000, 0, 1, 16'd0};

    reset = 1'b1;
    req_valid = '0;
    req_a = '0;
    req_b = '0;
    rsp_ready = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_req_ready", 32'(req_ready), 32'd0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_rsp_y", 32'(rsp_y), 32'd0);
    chk("rst_rsp_id", 32'(rsp_id), 32'd0);
    chk("rst_mult_a", 32'(mult_a), 32'd0);
    chk("rst_mult_b", 32'(mult_b), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    reset = 1'b0;
    model_last = NREQ - 1;

    // No requests: stays idle.
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); #1;
      chk("idle_no_req_ready", 32'(req_ready), 32'd0);
      chk("idle_no_rsp_valid", 32'(rsp_valid), 32'd0);
    end

    for (int i = 0; i < 9; i++)
      run_txn(tbl[i].valid, tbl[i].a, tbl[i].b, tbl[i].stall, tbl[i].exp_id, tbl[i].exp_y);

    // Operand sweep on requester 0, other lanes carry noise.
    blist = '{8'd0, 8'd1, 8'd2, 8'd127, 8'd128, 8'd254, 8'd255, 8'd0};
    for (int a = 0; a < 256; a++) begin
      for (int j = 0; j < 8; j++) begin
        ra = $urandom;
        rb = $urandom;
        ra[7:0] = 8'(a);
        rb[7:0] = (j == 7) ? 8'($urandom_range(0, 255)) : blist[j];
        ey = 16'(a * int'(rb[7:0]));
        run_txn(4'b0001, ra, rb, 0, 0, ey);
      end
    end
    chk("sweep_err", 32'(err), 32'd0);

    // Randomized traffic against the reference model.
    for (int i = 0; i < 300; i++) begin
      rv = 4'($urandom_range(1, 15));
      ra = $urandom;
      rb = $urandom;
      st = $urandom_range(0, 2);
      gid = ref_grant(rv);
      ey = 16'(int'(ra[gid*8 +: 8]) * int'(rb[gid*8 +: 8]));
      run_txn(rv, ra, rb, st, gid, ey);
    end
    chk("random_err", 32'(err), 32'd0);

    // Reset while in MUL: transaction discarded, priority back to requester 0.
    req_valid = 4'b1000;
    ra = 32'h11223344;
    req_a = ra;
    req_b = 32'h55667788;
    rsp_ready = 1'b1;
    gid = ref_grant(4'b1000);
    #1;
    chk("pre_rst_grant", 32'(req_ready), 32'(4'b0001 << gid));
    @(negedge clk); #1;
    chk("pre_rst_mult_a", 32'(mult_a), 32'h11);
    reset = 1'b1;
    @(negedge clk); #1;
    chk("midrst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("midrst_req_ready", 32'(req_ready), 32'd0);
    chk("midrst_err", 32'(err), 32'd0);
    chk("midrst_mult_a", 32'(mult_a), 32'd0);
    reset = 1'b0;
    model_last = NREQ - 1;
    last_acc = -100;
    run_txn(4'b1001, 32'h09000003, 32'h08000004, 0, 0, 16'd12);
    run_txn(4'b1001, 32'h09000003, 32'h08000004, 0, 3, 16'd72);

`ifdef MULT_ARB_CHECK_EN
    force_bad = 1'b1;
    run_txn(4'b0001, 32'h00000003, 32'h00000005, 0, 0, 16'h0000);
    force_bad = 1'b0;
    chk("chk_err_set", 32'(err), 32'd1);
    run_txn(4'b0001, 32'h00000003, 32'h00000005, 0, 0, 16'd15);
    chk("chk_err_sticky", 32'(err), 32'd1);
    reset = 1'b1;
    req_valid = '0;
    @(negedge clk); #1;
    reset = 1'b0;
    chk("chk_err_cleared", 32'(err), 32'd0);
`else
    chk("nochk_err", 32'(err), 32'd0);
`endif

    req_valid = '0;
    @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
